// File: rtl/uart_tx_if.sv
// uart_tx_if: AXI-Stream byte channel feeding the UART transmitter.
interface uart_tx_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   modport master (output tdata, output tvalid, input tready);
   modport slave (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serialises one AXI-Stream byte per frame as start, LSB-first data, optional check and stop bits.
// Bit periods end on tx_clk ticks from an external baud generator enabled by tx_clk_en.
module uart_tx #(
   parameter int data_bits  = 8,
   parameter int check_mode = 1,
   parameter int stop_bits  = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     tx_en,
   input  logic     tx_clk,
   uart_tx_if.slave s_axis,
   output logic     tx,
   output logic     tx_clk_en,
   output logic     busy
);
   typedef enum logic [4:0] {
      idle  = 5'b00001,
      start = 5'b00010,
      data  = 5'b00100,
      check = 5'b01000,
      stop  = 5'b10000
   } state_t;
   localparam logic [7:0] msk = 8'((1 << data_bits) - 1);
   localparam logic [2:0] last = 3'(data_bits - 1);
   localparam logic stop_last = 1'(stop_bits - 1);
   state_t st, st_nxt;
   logic [7:0] sh, sh_nxt, din;
   logic [2:0] cnt, cnt_nxt;
   logic stp, stp_nxt, chk, chk_nxt, rdy, rdy_nxt, tx_nxt, hs, tick;
   // tx_en gates tready combinationally so a handshake is never offered while disabled
   assign s_axis.tready = rdy & tx_en;
   assign hs = s_axis.tvalid & s_axis.tready;
   assign tick = tx_clk & tx_clk_en;
   assign din = s_axis.tdata & msk;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st <= idle;
         sh <= '0;
         cnt <= '0;
         stp <= 1'b0;
         chk <= 1'b0;
         rdy <= 1'b0;
         tx <= 1'b1;
         tx_clk_en <= 1'b0;
         busy <= 1'b0;
      end else begin
         st <= st_nxt;
         sh <= sh_nxt;
         cnt <= cnt_nxt;
         stp <= stp_nxt;
         chk <= chk_nxt;
         rdy <= rdy_nxt;
         tx <= tx_nxt;
         tx_clk_en <= st_nxt != idle;
         busy <= st_nxt != idle;
      end
   always_comb begin
      st_nxt = st;
      sh_nxt = sh;
      cnt_nxt = cnt;
      stp_nxt = stp;
      chk_nxt = chk;
      if (st != idle && !tx_en) begin
         st_nxt = idle;
         cnt_nxt = '0;
         stp_nxt = 1'b0;
      end else if (hs) begin
         st_nxt = start;
         sh_nxt = din;
         chk_nxt = check_mode == 1 ? ^din : check_mode == 2 ? ~^din : check_mode == 4;
      end else if (tick)
         case (st)
            start: st_nxt = data;
            data: begin
               sh_nxt = sh >> 1;
               cnt_nxt = cnt == last ? 3'd0 : cnt + 3'd1;
               st_nxt = cnt != last ? data : check_mode != 0 ? check : stop;
            end
            check: st_nxt = stop;
            stop: begin
               stp_nxt = stp == stop_last ? 1'b0 : stp + 1'b1;
               st_nxt = stp == stop_last ? idle : stop;
            end
            default: st_nxt = idle;
         endcase
   end
   // outputs are decoded from the next state so every pin comes straight from a flop
   always_comb begin
      tx_nxt = st_nxt == data ? sh_nxt[0] : st_nxt == check ? chk_nxt : st_nxt != start;
      rdy_nxt = st_nxt == idle && tx_en;
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame vectors over three configurations plus abort, reset and back-to-back sequences.
module tb_uart_tx;
   logic clk = 0, rst_n, tx_en, tx_clk;
   logic       tvalid [3];
   logic [7:0] tdata [3];
   logic       tx_w [3], busy_w [3], en_w [3], rdy_w [3];
   int vec = 0, err = 0;
   typedef struct {
      int         u;
      logic [7:0] d;
      logic [0:11] seq;
      int         n;
   } vec_t;
   vec_t tbl [6];
   always #5 clk = ~clk;
   uart_tx_if ax0 ();
   uart_tx_if ax1 ();
   uart_tx_if ax2 ();
   assign ax0.tvalid = tvalid[0];
   assign ax1.tvalid = tvalid[1];
   assign ax2.tvalid = tvalid[2];
   assign ax0.tdata = tdata[0];
   assign ax1.tdata = tdata[1];
   assign ax2.tdata = tdata[2];
   assign rdy_w[0] = ax0.tready;
   assign rdy_w[1] = ax1.tready;
   assign rdy_w[2] = ax2.tready;
   uart_tx #(.data_bits(8), .check_mode(1), .stop_bits(1)) u0 (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_clk(tx_clk), .s_axis(ax0),
      .tx(tx_w[0]), .tx_clk_en(en_w[0]), .busy(busy_w[0]));
   uart_tx #(.data_bits(5), .check_mode(2), .stop_bits(1)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_clk(tx_clk), .s_axis(ax1),
      .tx(tx_w[1]), .tx_clk_en(en_w[1]), .busy(busy_w[1]));
   uart_tx #(.data_bits(8), .check_mode(0), .stop_bits(2)) u2 (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_clk(tx_clk), .s_axis(ax2),
      .tx(tx_w[2]), .tx_clk_en(en_w[2]), .busy(busy_w[2]));

   task automatic cmp(input string name, input logic act, input logic exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pulse();
      tx_clk = 1;
      @(negedge clk);
      tx_clk = 0;
   endtask

   task automatic handshake(input int u, input logic [7:0] d);
      int k;
      tdata[u] = d;
      tvalid[u] = 1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!busy_w[u] && k < 10);
      cmp("handshake_taken", busy_w[u], 1'b1);
      tvalid[u] = 0;
      cmp("start_bit", tx_w[u], 1'b0);
      cmp("clk_en_frame", en_w[u], 1'b1);
      cmp("tready_busy", rdy_w[u], 1'b0);
   endtask

   task automatic frame_ticks(input int u, input logic [0:11] seq, input int n);
      for (int i = 1; i < n; i++) begin
         pulse();
         cmp("bit_after_tick", tx_w[u], seq[i]);
         @(negedge clk);
         cmp("bit_held", tx_w[u], seq[i]);
         cmp("busy_mid", busy_w[u], 1'b1);
      end
      pulse();
      cmp("end_tx_idle", tx_w[u], 1'b1);
      cmp("end_busy", busy_w[u], 1'b0);
      cmp("end_clk_en", en_w[u], 1'b0);
      cmp("end_tready", rdy_w[u], 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 8'hA5, 12'b010100101010, 11};
      tbl[1] = '{0, 8'h3C, 12'b000111100010, 11};
      tbl[2] = '{0, 8'h01, 12'b010000000110, 11};
      tbl[3] = '{1, 8'hFF, 12'b011111010000, 8};
      tbl[4] = '{1, 8'h03, 12'b011000110000, 8};
      tbl[5] = '{2, 8'h55, 12'b010101010110, 11};
      rst_n = 0;
      tx_en = 0;
      tx_clk = 0;
      for (int i = 0; i < 3; i++) begin
         tvalid[i] = 0;
         tdata[i] = 0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         cmp("rst_tx", tx_w[i], 1'b1);
         cmp("rst_tready", rdy_w[i], 1'b0);
         cmp("rst_clk_en", en_w[i], 1'b0);
         cmp("rst_busy", busy_w[i], 1'b0);
      end
      rst_n = 1;
      @(negedge clk);
      cmp("tready_disabled", rdy_w[0], 1'b0);
      tx_en = 1;
      @(negedge clk);
      cmp("tready_enabled", rdy_w[0], 1'b1);
      // ticks while idle with no data are ignored
      repeat (3) begin
         pulse();
         cmp("idle_tick_tx", tx_w[0], 1'b1);
         cmp("idle_tick_en", en_w[0], 1'b0);
         cmp("idle_tick_busy", busy_w[0], 1'b0);
      end
      foreach (tbl[v]) begin
         handshake(tbl[v].u, tbl[v].d);
         frame_ticks(tbl[v].u, tbl[v].seq, tbl[v].n);
         @(negedge clk);
      end
      // back-to-back with tvalid held high
      handshake(2, 8'h00);
      tdata[2] = 8'hFF;
      tvalid[2] = 1;
      frame_ticks(2, 12'b000000000110, 11);
      @(negedge clk);
      cmp("b2b_second_start", tx_w[2], 1'b0);
      cmp("b2b_second_busy", busy_w[2], 1'b1);
      tvalid[2] = 0;
      frame_ticks(2, 12'b011111111110, 11);
      @(negedge clk);
      // abort after the third data tick
      handshake(0, 8'hA5);
      repeat (4) pulse();
      cmp("abort_pre_tx", tx_w[0], 1'b0);
      tx_en = 0;
      @(negedge clk);
      cmp("abort_tx", tx_w[0], 1'b1);
      cmp("abort_busy", busy_w[0], 1'b0);
      cmp("abort_clk_en", en_w[0], 1'b0);
      cmp("abort_tready", rdy_w[0], 1'b0);
      tvalid[0] = 1;
      pulse();
      repeat (2) @(negedge clk);
      cmp("disabled_no_hs", busy_w[0], 1'b0);
      cmp("disabled_tready", rdy_w[0], 1'b0);
      cmp("disabled_tx", tx_w[0], 1'b1);
      tvalid[0] = 0;
      tx_en = 1;
      @(negedge clk);
      cmp("reenable_tready", rdy_w[0], 1'b1);
      cmp("reenable_no_resume", busy_w[0], 1'b0);
      // asynchronous reset in the middle of the data bits
      handshake(0, 8'hA5);
      repeat (2) pulse();
      cmp("pre_rst_tx", tx_w[0], 1'b0);
      rst_n = 0;
      #1;
      cmp("async_rst_tx", tx_w[0], 1'b1);
      cmp("async_rst_tready", rdy_w[0], 1'b0);
      cmp("async_rst_busy", busy_w[0], 1'b0);
      cmp("async_rst_en", en_w[0], 1'b0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      cmp("post_rst_tready", rdy_w[0], 1'b1);
      handshake(0, 8'h3C);
      frame_ticks(0, 12'b000111100010, 11);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
